// File: rtl/pll_init_pkg.sv
// Shared types, widths and helpers for the multi-channel PLL bring-up supervisor.
package pll_init_pkg;

  localparam int ICP_W  = 6;
  localparam int LPF_W  = 3;
  localparam int LOSS_W = 4;

  typedef enum logic [2:0] {
    RST_HOLD,
    WAIT_LOCK,
    STABLE,
    LOCKED,
    FAIL
  } pll_state_e;

  // Counter width large enough for the longest of the three phase limits.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

  // Charge-pump select for a calibration step, saturating at the field maximum.
  function automatic logic [ICP_W-1:0] icp_map(input int base, input int step, input int idx);
    int v;
    v = base + idx * step;
    if (v > 63) v = 63;
    return ICP_W'(v);
  endfunction

  // Loop-filter resistor: base value with bit0 flipped on odd steps.
  function automatic logic [LPF_W-1:0] lpf_map(input logic [LPF_W-1:0] base, input logic [3:0] idx);
    return base ^ {2'b00, idx[0]};
  endfunction

endpackage

// File: rtl/pll_init_chan.sv
// One supervised PLL channel: lock synchroniser, bring-up FSM, phase counter
// and calibration mapping.
module pll_init_chan
  import pll_init_pkg::*;
#(
  parameter int               RST_CYCLES    = 64,
  parameter int               LOCK_TIMEOUT  = 4096,
  parameter int               STABLE_CYCLES = 256,
  parameter int               CAL_STEPS     = 4,
  parameter logic [ICP_W-1:0] ICP_BASE      = 6'd8,
  parameter logic [ICP_W-1:0] ICP_STEP      = 6'd4,
  parameter logic [LPF_W-1:0] LPF_BASE      = 3'd2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lock_i,
  input  logic              relock_i,
  output logic              pll_rst_o,
  output logic [ICP_W-1:0]  icpsel_o,
  output logic [LPF_W-1:0]  lpfres_o,
  output logic              lock_o,
  output logic              fail_o,
  output logic [LOSS_W-1:0] loss_o
);

  localparam int            CW       = cnt_w(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    CAL_LAST = 4'(CAL_STEPS - 1);

  logic [1:0]        sync_q;
  logic              lock_s;
  pll_state_e        state_q;
  logic [CW-1:0]     cnt_q;
  logic [3:0]        cal_q;
  logic [3:0]        cal_d;
  logic [ICP_W-1:0]  icp_q;
  logic [LPF_W-1:0]  lpf_q;
  logic              rst_q;
  logic              lock_q;
  logic              fail_q;
  logic [LOSS_W-1:0] loss_q;

  assign lock_s = sync_q[1];
  assign cal_d  = cal_q + 4'd1;

  // Two-flop synchroniser for the raw lock, which is asynchronous to this clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], lock_i};
  end

  // Bring-up FSM; every output is registered and updated alongside the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RST_HOLD;
      cnt_q   <= '0;
      cal_q   <= '0;
      icp_q   <= ICP_BASE;
      lpf_q   <= LPF_BASE;
      rst_q   <= 1'b1;
      lock_q  <= 1'b0;
      fail_q  <= 1'b0;
      loss_q  <= '0;
    end else if (relock_i) begin
      // Manual restart overrides everything; loss history survives.
      state_q <= RST_HOLD;
      cnt_q   <= '0;
      cal_q   <= '0;
      icp_q   <= icp_map(int'(ICP_BASE), int'(ICP_STEP), 0);
      lpf_q   <= LPF_BASE;
      rst_q   <= 1'b1;
      lock_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      case (state_q)
        RST_HOLD: begin
          if (cnt_q == RST_LAST) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            rst_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_q <= '0;
            rst_q <= 1'b1;
            if (cal_q == CAL_LAST) begin
              state_q <= FAIL;
              fail_q  <= 1'b1;
            end else begin
              // Next calibration step: new settings land together with the PLL reset.
              state_q <= RST_HOLD;
              cal_q   <= cal_d;
              icp_q   <= icp_map(int'(ICP_BASE), int'(ICP_STEP), int'(cal_d));
              lpf_q   <= lpf_map(LPF_BASE, cal_d);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STABLE: begin
          // A drop restarts both qualification and the lock timeout.
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == ST_LAST) begin
            state_q <= LOCKED;
            cnt_q   <= '0;
            lock_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        LOCKED: begin
          // Lost lock: count it and retry at the same calibration step.
          if (!lock_s) begin
            state_q <= RST_HOLD;
            cnt_q   <= '0;
            rst_q   <= 1'b1;
            lock_q  <= 1'b0;
            if (loss_q != {LOSS_W{1'b1}}) loss_q <= loss_q + LOSS_W'(1);
          end
        end
        FAIL: begin
          rst_q  <= 1'b1;
          fail_q <= 1'b1;
        end
        default: begin
          state_q <= RST_HOLD;
          cnt_q   <= '0;
          rst_q   <= 1'b1;
        end
      endcase
    end
  end

  assign pll_rst_o = rst_q;
  assign icpsel_o  = icp_q;
  assign lpfres_o  = lpf_q;
  assign lock_o    = lock_q;
  assign fail_o    = fail_q;
  assign loss_o    = loss_q;

endmodule

// File: rtl/pll_init_multi.sv
// Multi-channel PLL bring-up supervisor: NUM_PLL independent channels plus a
// registered all-channels-locked flag.
module pll_init_multi
  import pll_init_pkg::*;
#(
  parameter int               NUM_PLL       = 2,
  parameter int               RST_CYCLES    = 64,
  parameter int               LOCK_TIMEOUT  = 4096,
  parameter int               STABLE_CYCLES = 256,
  parameter int               CAL_STEPS     = 4,
  parameter logic [ICP_W-1:0] ICP_BASE      = 6'd8,
  parameter logic [ICP_W-1:0] ICP_STEP      = 6'd4,
  parameter logic [LPF_W-1:0] LPF_BASE      = 3'd2
) (
  input  logic                        init_clk,
  input  logic                        reset,
  input  logic [NUM_PLL-1:0]          pll_lock,
  input  logic [NUM_PLL-1:0]          relock_req,
  output logic [NUM_PLL-1:0]          pll_rst,
  output logic [ICP_W*NUM_PLL-1:0]    icpsel,
  output logic [LPF_W*NUM_PLL-1:0]    lpfres,
  output logic [NUM_PLL-1:0]          o_lock,
  output logic [NUM_PLL-1:0]          fail,
  output logic [LOSS_W*NUM_PLL-1:0]   loss_cnt,
  output logic                        all_locked
);

  for (genvar g = 0; g < NUM_PLL; g++) begin : g_chan
    pll_init_chan #(
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .CAL_STEPS    (CAL_STEPS),
      .ICP_BASE     (ICP_BASE),
      .ICP_STEP     (ICP_STEP),
      .LPF_BASE     (LPF_BASE)
    ) u_chan (
      .clk_i    (init_clk),
      .rst_i    (reset),
      .lock_i   (pll_lock[g]),
      .relock_i (relock_req[g]),
      .pll_rst_o(pll_rst[g]),
      .icpsel_o (icpsel[ICP_W*g +: ICP_W]),
      .lpfres_o (lpfres[LPF_W*g +: LPF_W]),
      .lock_o   (o_lock[g]),
      .fail_o   (fail[g]),
      .loss_o   (loss_cnt[LOSS_W*g +: LOSS_W])
    );
  end

  // Aggregate lock flag, one cycle behind the per-channel o_lock vector.
  always_ff @(posedge init_clk or posedge reset) begin
    if (reset) all_locked <= 1'b0;
    else       all_locked <= &o_lock;
  end

endmodule
